// File: rtl/ps2_key_event_controller.sv
// Decodes the PS/2 scan-code stream into held-key levels and press/release events for the maze game.
// Latency: byte strobe in cycle N -> held and show-ahead FIFO head valid at N+1.
// Backpressure: evt_valid/evt_ready; a full FIFO with no pop drops the event and sets sticky overflow.
module ps2_key_event_controller #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] rx_data,
  input  logic       rx_data_en,
  output logic       wait_for_incoming_data,
  output logic       start_receiving_data,
  output logic [5:0] held,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [2:0] evt_code,
  output logic       evt_release,
  output logic       prefix_timeout,
  output logic       overflow,
  input  logic       clear_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  typedef struct packed {
    logic [2:0] code;
    logic       rel;
  } evt_t;

  state_t          state, state_nxt;
  logic [TO_W-1:0] timer;
  logic            timeout_fire;
  logic            dec_vld, dec_ext, dec_brk;
  logic [3:0]      key_map;
  logic            key_hit;
  logic [2:0]      key_idx;
  logic            push, pop, full, push_ok, drop;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  evt_t            mem [FIFO_DEPTH];
  evt_t            head;

  // {valid, key index}; arrows and WASD share the same direction indices.
  function automatic logic [3:0] map_key(input logic ext, input logic [7:0] code);
    logic [3:0] r;
    r = 4'b0000;
    if (ext) begin
      case (code)
        8'h75:   r = 4'b1000;
        8'h72:   r = 4'b1001;
        8'h6B:   r = 4'b1010;
        8'h74:   r = 4'b1011;
        default: r = 4'b0000;
      endcase
    end else begin
      case (code)
        8'h1D:   r = 4'b1000;
        8'h1B:   r = 4'b1001;
        8'h1C:   r = 4'b1010;
        8'h23:   r = 4'b1011;
        8'h5A:   r = 4'b1100;
        8'h76:   r = 4'b1101;
        default: r = 4'b0000;
      endcase
    end
    return r;
  endfunction

  assign start_receiving_data = 1'b0;

  // Prefix state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Prefix decoding; a byte arriving on the timeout cycle takes priority over abandoning the prefix.
  always_comb begin
    state_nxt    = state;
    dec_vld      = 1'b0;
    dec_ext      = 1'b0;
    dec_brk      = 1'b0;
    timeout_fire = enable && (state != S_IDLE) && !rx_data_en &&
                   (timer == TO_W'(TIMEOUT_CYCLES - 1));
    if (!enable) begin
      state_nxt = S_IDLE;
    end else if (rx_data_en) begin
      case (state)
        S_IDLE: begin
          if (rx_data == 8'hE0)      state_nxt = S_EXT;
          else if (rx_data == 8'hF0) state_nxt = S_BRK;
          else if (!(rx_data inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1})) dec_vld = 1'b1;
        end
        S_EXT: begin
          if (rx_data == 8'hF0) begin
            state_nxt = S_EXT_BRK;
          end else if (rx_data != 8'hE0) begin
            dec_vld   = 1'b1;
            dec_ext   = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_BRK: begin
          dec_vld   = 1'b1;
          dec_brk   = 1'b1;
          state_nxt = S_IDLE;
        end
        default: begin
          dec_vld   = 1'b1;
          dec_ext   = 1'b1;
          dec_brk   = 1'b1;
          state_nxt = S_IDLE;
        end
      endcase
    end else if (timeout_fire) begin
      state_nxt = S_IDLE;
    end
  end

  assign key_map = map_key(dec_ext, rx_data);
  assign key_idx = key_map[2:0];
  assign key_hit = dec_vld && key_map[3];
  // Only edges of the held level become events: typematic repeats and stray breaks are dropped.
  assign push    = key_hit && (held[key_idx] == dec_brk);

  // Prefix timer runs only while a prefix is pending and restarts on every byte.
  always_ff @(posedge clk) begin
    if (reset || !enable || (state == S_IDLE) || rx_data_en || timeout_fire) timer <= '0;
    else timer <= timer + TO_W'(1);
  end

  // Timeout pulse and receiver arming.
  always_ff @(posedge clk) begin
    if (reset) begin
      prefix_timeout         <= 1'b0;
      wait_for_incoming_data <= 1'b0;
    end else begin
      prefix_timeout         <= timeout_fire;
      wait_for_incoming_data <= enable;
    end
  end

  // Held key levels; disabling the controller releases everything silently.
  always_ff @(posedge clk) begin
    if (reset || !enable) held <= '0;
    else if (push)        held[key_idx] <= !dec_brk;
  end

  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign full      = (count == CW'(FIFO_DEPTH));
  assign push_ok   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign head      = mem[rd_ptr];

  assign evt_code    = evt_valid ? head.code : 3'd0;
  assign evt_release = evt_valid ? head.rel  : 1'b0;

  // Event storage; contents need no reset because count gates the outputs.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= '{code: key_idx, rel: dec_brk};
  end

  // FIFO pointers and occupancy; drains even while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a new drop beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)               overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

endmodule
